// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared state encoding and access-size constants
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported memory between fetch and data ports
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_flush,
    output logic        fetch_ready,
    output logic        fetch_resp_valid,
    output logic [31:0] fetch_rdata,
    input  logic        data_valid,
    input  logic [31:0] data_addr,
    input  logic        data_write,
    input  logic [31:0] data_wdata,
    input  logic [1:0]  data_size,
    output logic        data_ready,
    output logic        data_resp_valid,
    output logic [31:0] data_rdata,
    output logic        mem_req_valid,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    arb_state_e state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       drop_q, drop_d;
    logic       store_q, store_d;
    logic       fetch_cand, pick_fetch, grant;

    // Arbitration and combinational request/response routing; everything is held at 0 while in reset
    always_comb begin
        fetch_cand       = fetch_valid & ~fetch_flush;
        pick_fetch       = fetch_cand & (~data_valid | (starve_q == 4'(STARVE_LIMIT)));
        mem_req_valid    = ~reset & (state_q == IDLE) & (fetch_cand | data_valid);
        mem_addr         = ~mem_req_valid ? 32'd0 : pick_fetch ? fetch_addr : data_addr;
        mem_write        = mem_req_valid & ~pick_fetch & data_write;
        mem_wdata        = (mem_req_valid & ~pick_fetch) ? data_wdata : 32'd0;
        mem_size         = ~mem_req_valid ? 2'd0 : pick_fetch ? SIZE_WORD : data_size;
        grant            = mem_req_valid & mem_req_ready;
        fetch_ready      = grant & pick_fetch;
        data_ready       = grant & ~pick_fetch;
        fetch_resp_valid = ~reset & (state_q == BUSY_I) & mem_resp_valid & ~drop_q & ~fetch_flush;
        fetch_rdata      = fetch_resp_valid ? mem_rdata : 32'd0;
        data_resp_valid  = ~reset & (state_q == BUSY_D) & mem_resp_valid;
        data_rdata       = (data_resp_valid & ~store_q) ? mem_rdata : 32'd0;
        busy             = ~reset & (state_q != IDLE);
    end

    // Next-state: grants open a transaction, the response closes it; a redirect poisons an in-flight fetch
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        drop_d   = drop_q;
        store_d  = store_q;
        if (state_q == IDLE) begin
            drop_d = 1'b0;
            if (fetch_ready) begin
                state_d  = BUSY_I;
                starve_d = 4'd0;
            end else if (data_ready) begin
                state_d  = BUSY_D;
                store_d  = data_write;
                starve_d = (fetch_cand && starve_q < 4'(STARVE_LIMIT)) ? starve_q + 4'd1 : starve_q;
            end
        end else if (mem_resp_valid) begin
            state_d = IDLE;
            drop_d  = 1'b0;
        end else if (state_q == BUSY_I && fetch_flush) begin
            drop_d = 1'b1;
        end
    end

    // State registers with synchronous reset abandoning any outstanding transaction
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
            drop_q   <= 1'b0;
            store_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
            store_q  <= store_d;
        end
    end

endmodule
